// File: rtl/mod_reduce_seq_if.sv
// Valid/ready stream bundle with start/end-of-packet, error and sideband control.
// 'source' drives data towards 'sink'; 'master'/'slave' are aliases of the same directions.
interface if_axi_stream #(
    parameter int DAT_BITS = 8,
    parameter int CTL_BITS = 8,
    parameter int MOD_BITS = 1
);
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic                err;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;
    logic [MOD_BITS-1:0] mod;

    modport source (output val, sop, eop, err, dat, ctl, mod, input rdy);
    modport sink   (input  val, sop, eop, err, dat, ctl, mod, output rdy);
    modport master (output val, sop, eop, err, dat, ctl, mod, input rdy);
    modport slave  (input  val, sop, eop, err, dat, ctl, mod, output rdy);
endinterface

// File: rtl/mod_reduce_seq.sv
// Bit-serial reducer: product mod P, one product bit per cycle via shift/compare/subtract.
// Optional MOD_REDUCE_EARLY_EXIT_EN bypasses the loop for inputs already below P.
module mod_reduce_seq #(
    parameter int              DAT_BITS = 381,
    parameter int              CTL_BITS = 8,
    parameter logic [DAT_BITS:0] P      = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    if_axi_stream.sink   i_mul,
    if_axi_stream.source o_mod
);
    localparam int PRD_BITS = 2 * DAT_BITS;
    localparam int CNT_BITS = $clog2(PRD_BITS);

    // P is one bit wider than the result so an oversized modulus is caught here.
    generate
        if (P == '0 || P[DAT_BITS] != 1'b0) begin : g_bad_modulus
            $error("mod_reduce_seq: P must be nonzero and below 2**DAT_BITS");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

    state_t               r_state;
    logic [PRD_BITS-1:0]  r_x;
    logic [DAT_BITS-1:0]  r_rem;
    logic [CNT_BITS-1:0]  r_cnt;
    logic [CTL_BITS-1:0]  r_ctl;
    logic                 r_val;
    logic                 r_sop;
    logic                 r_eop;
    logic                 r_err;

    logic [DAT_BITS:0]    w_t;
    logic [DAT_BITS:0]    w_diff;
    logic                 w_ge;
    logic [DAT_BITS-1:0]  w_rem_next;
    logic                 w_unused;

    // r < P keeps t < 2P, so a single conditional subtract restores the invariant.
    assign w_t        = {r_rem, r_x[r_cnt]};
    assign w_ge       = (w_t >= P);
    assign w_diff     = w_t - P;
    assign w_rem_next = w_ge ? w_diff[DAT_BITS-1:0] : w_t[DAT_BITS-1:0];
    assign w_unused   = ^{i_mul.mod, w_diff[DAT_BITS]};

`ifdef MOD_REDUCE_EARLY_EXIT_EN
    logic w_early;
    assign w_early = (i_mul.dat[PRD_BITS-1:DAT_BITS] == '0) &&
                     ({1'b0, i_mul.dat[DAT_BITS-1:0]} < P);
`endif

    assign i_mul.rdy = (r_state == IDLE);

    assign o_mod.val = r_val;
    assign o_mod.dat = r_rem;
    assign o_mod.ctl = r_ctl;
    assign o_mod.sop = r_sop;
    assign o_mod.eop = r_eop;
    assign o_mod.err = r_err;
    assign o_mod.mod = '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_ctl   <= '0;
            r_val   <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_mul.val) begin
                        r_x   <= i_mul.dat;
                        r_ctl <= i_mul.ctl;
                        r_sop <= i_mul.sop;
                        r_eop <= i_mul.eop;
                        r_err <= i_mul.err;
                        r_cnt <= CNT_BITS'(PRD_BITS - 1);
`ifdef MOD_REDUCE_EARLY_EXIT_EN
                        if (w_early) begin
                            r_rem   <= i_mul.dat[DAT_BITS-1:0];
                            r_val   <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_rem   <= '0;
                            r_state <= REDUCE;
                        end
`else
                        r_rem   <= '0;
                        r_state <= REDUCE;
`endif
                    end
                end
                REDUCE: begin
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_val   <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (o_mod.rdy) begin
                        r_val   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_val   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mod_reduce_seq.sv
// Directed bench for mod_reduce_seq with DAT_BITS=8, P=251; latency expectations
// follow MOD_REDUCE_EARLY_EXIT_EN.
module tb_mod_reduce_seq;
    localparam int DB = 8;
    localparam int CB = 8;
`ifdef MOD_REDUCE_EARLY_EXIT_EN
    localparam int LAT_SMALL = 1;
`else
    localparam int LAT_SMALL = 17;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_axi_stream #(.DAT_BITS(2*DB), .CTL_BITS(CB)) mul_if();
    if_axi_stream #(.DAT_BITS(DB),   .CTL_BITS(CB)) mod_if();

    mod_reduce_seq #(.DAT_BITS(DB), .CTL_BITS(CB), .P(9'd251)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .i_mul (mul_if.sink),
        .o_mod (mod_if.source)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int ne     = 0;
    int n_acc  = 0;
    int n_xfer = 0;
    int acc_edge [16];
    logic [7:0] out_q [$];

    // Edge counter plus accept/transfer monitor, sampling pre-edge values.
    always @(posedge clk) begin
        ne++;
        if (!rst && mul_if.val && mul_if.rdy) begin
            if (n_acc < 16) acc_edge[n_acc] = ne;
            n_acc++;
        end
        if (!rst && mod_if.val && mod_if.rdy) begin
            n_xfer++;
            out_q.push_back(mod_if.dat);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(logic [15:0] x, logic [7:0] c, logic s, logic e, logic r);
        int a0;
        int guard;
        a0 = n_acc;
        guard = 0;
        mul_if.dat = x;
        mul_if.ctl = c;
        mul_if.sop = s;
        mul_if.eop = e;
        mul_if.err = r;
        mul_if.val = 1'b1;
        while (n_acc == a0 && guard < 100) begin
            tick();
            guard++;
        end
        mul_if.val = 1'b0;
        check("accept", n_acc - a0, 1);
    endtask

    task automatic wait_val(output int lat);
        lat = 1;
        while (!mod_if.val && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic get_result(string tag, logic [7:0] exp_dat, int exp_lat);
        int lat;
        wait_val(lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_dat"}, mod_if.dat, exp_dat);
        tick();
        check({tag, "_val_drop"}, mod_if.val, 1'b0);
    endtask

    initial begin
        int lat;
        int a;
        int x0;
        int q0;
        int guard;
        logic [15:0] xs [4];
        logic [7:0]  ex [4];
        int          lt [4];

        mul_if.val = 1'b0;
        mul_if.dat = '0;
        mul_if.ctl = '0;
        mul_if.sop = 1'b0;
        mul_if.eop = 1'b0;
        mul_if.err = 1'b0;
        mul_if.mod = '0;
        mod_if.rdy = 1'b1;

        // Reset state
        tick(); tick(); tick();
        check("rst_val", mod_if.val, 1'b0);
        check("rst_dat", mod_if.dat, 8'd0);
        check("rst_ctl", mod_if.ctl, 8'd0);
        check("rst_flags", {mod_if.sop, mod_if.eop, mod_if.err}, 3'b000);
        check("rst_mod", mod_if.mod, 1'b0);
        check("rst_in_rdy", mul_if.rdy, 1'b1);
        rst = 1'b0;
        tick();
        $display("reset released");

        // 1: basic reduction with sideband passthrough
        send(16'd40000, 8'h5A, 1'b1, 1'b1, 1'b0);
        wait_val(lat);
        check("t1_lat", lat, 17);
        check("t1_dat", mod_if.dat, 8'd91);
        check("t1_ctl", mod_if.ctl, 8'h5A);
        check("t1_sop_eop", {mod_if.sop, mod_if.eop}, 2'b11);
        check("t1_err", mod_if.err, 1'b0);
        tick();
        check("t1_val_drop", mod_if.val, 1'b0);
        check("t1_in_rdy", mul_if.rdy, 1'b1);
        check("t1_xfer", n_xfer, 1);
        $display("t1 x=40000 -> %0d latency %0d", out_q[0], lat);

        // 2: boundary values
        xs[0] = 16'd65025; ex[0] = 8'd16;  lt[0] = 17;
        xs[1] = 16'd251;   ex[1] = 8'd0;   lt[1] = 17;
        xs[2] = 16'd0;     ex[2] = 8'd0;   lt[2] = LAT_SMALL;
        xs[3] = 16'd250;   ex[3] = 8'd250; lt[3] = LAT_SMALL;
        for (int i = 0; i < 4; i++) begin
            send(xs[i], 8'(i), 1'b0, 1'b0, 1'b0);
            get_result($sformatf("t2_%0d", i), ex[i], lt[i]);
            $display("t2 x=%0d expected %0d latency %0d", xs[i], ex[i], lt[i]);
        end

        // 3: backpressure holds the result stable
        mod_if.rdy = 1'b0;
        send(16'd40000, 8'h33, 1'b1, 1'b0, 1'b0);
        wait_val(lat);
        check("t3_lat", lat, 17);
        x0 = n_xfer;
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_val", mod_if.val, 1'b1);
            check("t3_hold_dat", mod_if.dat, 8'd91);
            check("t3_hold_in_rdy", mul_if.rdy, 1'b0);
            tick();
        end
        check("t3_no_xfer", n_xfer, x0);
        mod_if.rdy = 1'b1;
        tick();
        check("t3_one_xfer", n_xfer, x0 + 1);
        check("t3_val_drop", mod_if.val, 1'b0);
        $display("t3 backpressure released, transfers %0d", n_xfer - x0);

        // 4: back-to-back with upstream holding val
        a = n_acc;
        q0 = out_q.size();
        mul_if.dat = 16'd65025;
        mul_if.ctl = 8'h01;
        mul_if.val = 1'b1;
        guard = 0;
        while (n_acc == a && guard < 100) begin tick(); guard++; end
        mul_if.dat = 16'd40000;
        mul_if.ctl = 8'h02;
        check("t4_busy_rdy", mul_if.rdy, 1'b0);
        guard = 0;
        while (n_acc == a + 1 && guard < 100) begin tick(); guard++; end
        mul_if.val = 1'b0;
        check("t4_accepts", n_acc - a, 2);
        check("t4_spacing", acc_edge[a+1] - acc_edge[a], 18);
        guard = 0;
        while (out_q.size() < q0 + 2 && guard < 100) begin tick(); guard++; end
        check("t4_count", out_q.size() - q0, 2);
        check("t4_first", out_q[q0], 8'd16);
        check("t4_second", out_q[q0+1], 8'd91);
        $display("t4 back-to-back spacing %0d", acc_edge[a+1] - acc_edge[a]);

        // 5: reset in the sixth REDUCE cycle aborts the item
        x0 = n_xfer;
        send(16'd40000, 8'h77, 1'b1, 1'b1, 1'b0);
        tick(); tick(); tick(); tick(); tick();
        check("t5_busy_rdy", mul_if.rdy, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_val", mod_if.val, 1'b0);
        check("t5_in_rdy", mul_if.rdy, 1'b1);
        for (int i = 0; i < 25; i++) tick();
        check("t5_no_output", n_xfer, x0);
        $display("t5 reset abort, transfers since %0d", n_xfer - x0);

        // 6: error flag passes through with a real result
        send(16'd300, 8'h0E, 1'b1, 1'b1, 1'b1);
        wait_val(lat);
        check("t6_lat", lat, 17);
        check("t6_dat", mod_if.dat, 8'd49);
        check("t6_err", mod_if.err, 1'b1);
        check("t6_mod", mod_if.mod, 1'b0);
        check("t6_ctl", mod_if.ctl, 8'h0E);
        tick();
        check("t6_val_drop", mod_if.val, 1'b0);
        $display("t6 x=300 err passthrough");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
